// File: rtl/synth_voice_bank.sv
// synth_voice_bank: polyphonic oscillator bank and mixer feeding the I2S DAC.
// Each frame strobe presents the sample computed during the previous frame,
// then sweeps all voices one per cycle to compute the next sample.
// Optional feature: define SYNTH_SQUARE_EN to let voices select a square wave
// (cfg_wave=1); without it every voice is a sawtooth and cfg_wave is ignored.
module synth_voice_bank #(
    parameter  int NUM_VOICES = 8,
    localparam int VW         = $clog2(NUM_VOICES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_strobe,
    input  logic          cfg_we,
    output logic          cfg_ready,
    input  logic [VW-1:0] cfg_voice,
    input  logic [23:0]   cfg_inc,
    input  logic [6:0]    cfg_vel,
    input  logic          cfg_gate,
    input  logic          cfg_wave,
    output logic [23:0]   dac_l,
    output logic [23:0]   dac_r,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // The sweep counter runs one beat past the last voice to drain the term pipe.
    localparam logic [VW:0]          CNT_LAST = (VW + 1)'(NUM_VOICES);
    localparam logic signed [26:0]   SAT_MAX  = 27'sd8388607;
    localparam logic signed [26:0]   SAT_MIN  = -27'sd8388608;

    // Control
    state_t state_q, state_d;
    logic   start;
    logic   step;
    logic   commit;
    logic   cfg_accept;

    // Per-voice register file
    logic [23:0]           phase_q [NUM_VOICES];
    logic [23:0]           inc_q   [NUM_VOICES];
    logic [6:0]            vel_q   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q;
    logic [NUM_VOICES-1:0] wave_q;
    logic [NUM_VOICES-1:0] restart_q;

    // Sweep datapath
    logic [VW:0]        cnt_q;
    logic [VW-1:0]      idx;
    logic               issue;
    logic [23:0]        p_cur;
    logic [23:0]        phase_next;
    logic signed [15:0] saw_val;
    logic signed [15:0] osc_val;
    logic signed [23:0] product;
    logic signed [22:0] term_next;
    logic signed [22:0] term_q;
    logic signed [26:0] acc_q;
    logic [23:0]        sat_val;
    logic [23:0]        pending_q;

    // Output side
    logic [23:0] dac_q;
    logic        overrun_q;

    assign busy       = (state_q != IDLE);
    assign cfg_ready  = ~busy;
    assign cfg_accept = cfg_we & cfg_ready;
    assign dac_l      = dac_q;
    assign dac_r      = dac_q;
    assign overrun    = overrun_q;

    assign idx   = cnt_q[VW-1:0];
    assign issue = (state_q == SWEEP) && (cnt_q != CNT_LAST);

`ifndef SYNTH_SQUARE_EN
    // Waveform select is stored but has no effect in the saw-only build.
    logic unused_wave;
    assign unused_wave = ^wave_q;
`endif

    // State register for the sweep sequencer.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control pulses: start a sweep, step through voices, commit the sum.
    // NOTE: every output of this block gets a default first so no path leaves
    // a value held, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    start   = 1'b1;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Oscillator for the voice currently selected by the sweep counter.
    always_comb begin
        p_cur   = restart_q[idx] ? 24'd0 : phase_q[idx];
        saw_val = {~p_cur[23], p_cur[22:8]};
`ifdef SYNTH_SQUARE_EN
        if (wave_q[idx]) begin
            osc_val = p_cur[23] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            osc_val = saw_val;
        end
`else
        osc_val = saw_val;
`endif
        // |-32768 * 127| fits in 23 signed bits, so the top product bit is redundant.
        product    = osc_val * $signed({1'b0, vel_q[idx]});
        term_next  = gate_q[idx] ? product[22:0] : 23'sd0;
        phase_next = gate_q[idx] ? (p_cur + inc_q[idx]) : 24'd0;
    end

    // Clamp the 27-bit mix to the 24-bit signed DAC range.
    always_comb begin
        if (acc_q > SAT_MAX) begin
            sat_val = 24'h7FFFFF;
        end else if (acc_q < SAT_MIN) begin
            sat_val = 24'h800000;
        end else begin
            sat_val = acc_q[23:0];
        end
    end

    // Voice register file: config writes while idle, phase advance during the sweep.
    // NOTE: the voice arrays sit in the async reset on purpose: a note left
    // sounding across reset would be audible, so they cannot be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                inc_q[v]   <= '0;
                vel_q[v]   <= '0;
            end
            gate_q    <= '0;
            wave_q    <= '0;
            restart_q <= '0;
        end else if (cfg_accept) begin
            inc_q[cfg_voice]  <= cfg_inc;
            vel_q[cfg_voice]  <= cfg_vel;
            gate_q[cfg_voice] <= cfg_gate;
            wave_q[cfg_voice] <= cfg_wave;
            if (cfg_gate) begin
                restart_q[cfg_voice] <= 1'b1;
            end
        end else if (issue) begin
            phase_q[idx]   <= phase_next;
            restart_q[idx] <= 1'b0;
        end
    end

    // Two-stage mix pipe: register each voice term, add it one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            term_q    <= '0;
            acc_q     <= '0;
            pending_q <= '0;
        end else begin
            if (start) begin
                cnt_q  <= '0;
                term_q <= '0;
                acc_q  <= '0;
            end else if (step) begin
                cnt_q  <= cnt_q + 1'b1;
                acc_q  <= acc_q + 27'(term_q);
                term_q <= issue ? term_next : 23'sd0;
            end
            if (commit) begin
                pending_q <= sat_val;
            end
        end
    end

    // Frame output: present the pending sample on every strobe, flag strobes during a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_q     <= '0;
            overrun_q <= 1'b0;
        end else if (sample_strobe) begin
            dac_q <= pending_q;
            if (busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/synth_voice_bank.md
Name: synth_voice_bank

Overview:
- Polyphonic oscillator bank and mixer for the MIDI synth; sits directly upstream of the PmodI2S2 I2S controller and drives its dac_l/dac_r inputs.
- Voice settings come from the MIDI parser through a write port.
- Once per audio frame, triggered by the controller's dac_rd_adc_wr pulse, it presents the previously computed sample. It then sweeps all voices time-multiplexed to compute the next sample (one frame of latency).

Parameters:
- NUM_VOICES, 8, number of voices; power of two, 2..16.
- VW, $clog2(NUM_VOICES), voice index width (localparam).

Ports:
- clk  in  1  system clock, 98.304 MHz
- rst_n  in  1  asynchronous active-low reset
- sample_strobe  in  1  frame pulse; connect to dac_rd_adc_wr
- cfg_we  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_we=1 and cfg_ready=1
- cfg_voice  in  VW  target voice
- cfg_inc  in  24  phase increment per sample
- cfg_vel  in  7  velocity/amplitude, unsigned 0..127
- cfg_gate  in  1  1 = note on, 0 = note off
- cfg_wave  in  1  waveform select, 0 = saw, 1 = square (see Optional Feature)
- dac_l  out  24  left sample, signed
- dac_r  out  24  right sample, signed, always equal to dac_l
- busy  out  1  sweep in progress
- overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - every voice's phase, inc, vel, gate, wave and restart flag;
  - the pending sample, the accumulator, dac_l, dac_r, busy and overrun;
  - the state machine (goes to IDLE).
- cfg_ready = ~busy.
- Accepted write (cfg_we & cfg_ready) loads inc/vel/gate/wave of cfg_voice. If cfg_gate=1, it also sets that voice's restart flag.
- FSM states are IDLE, SWEEP and FLUSH.
- IDLE: on sample_strobe, at the next edge:
  - dac_l/dac_r take the pending sample;
  - the accumulator is cleared and the voice counter is set to 0;
  - state goes to SWEEP and busy rises.
- SWEEP: one voice per cycle, index i = 0..NUM_VOICES-1.
  - Phase used: p = restart ? 0 : phase[i].
  - Saw value: s = signed 16-bit {~p[23], p[22:8]}, i.e. p[23:8] xor 0x8000.
  - Product: s times zero-extended vel, giving a 23-bit signed term.
  - Term is 0 if gate=0.
  - Phase update: phase[i] = gate ? p + inc : 0 (24-bit wrap-around). The restart flag is cleared.
  - The term is registered, then added to a 27-bit signed accumulator on the following cycle (2-stage pipe).
- FLUSH (1 cycle): the last term is added. At the following edge:
  - pending = saturate(acc) to the range [-8388608, 8388607];
  - busy falls and state returns to IDLE.
- busy is high for NUM_VOICES+2 cycles after the strobe edge.
- sample_strobe while busy:
  - dac_l/dac_r load the current (old) pending sample;
  - overrun is set;
  - the running sweep continues and is not restarted.
  - overrun is cleared only by reset.
- Reset mid-sweep aborts immediately; the next strobe outputs 0.
- The first strobe after reset outputs 0.

Optional Feature:
- Macro: SYNTH_SQUARE_EN.
- Defined: a voice with wave=1 uses s = p[23] ? -32768 : +32767; wave=0 uses saw.
- Undefined: the wave register and the cfg_wave input are ignored; all voices use saw.

Test Plan:
- Reset: hold rst_n=0 mid-sweep, release -> all outputs 0, cfg_ready=1; first strobe -> dac_l=dac_r=0x000000.
- Single saw voice:
  - stimulus: voice 0, inc=0x100000, vel=127, gate=1; strobes every 2048 clocks;
  - required response: dac_l after strobes 1, 2, 3 = 0x000000, 0xC08000, 0xC87000;
  - dac_r=dac_l on every strobe.
- Negative saturation: voices 0-2, inc=0, vel=127, gate=1 (sum -12484608) -> dac_l=0x800000 from the 2nd strobe on.
- Positive saturation, SYNTH_SQUARE_EN defined: same setup with wave=1 -> dac_l=0x7FFFFF. Without the macro -> 0x800000.
- Handshake: cfg_we held on the cycle after a strobe -> cfg_ready=0 for exactly NUM_VOICES+2 cycles, then the write is accepted. Note-off (gate=0) -> that voice contributes 0 from the next computed sample.
- Overrun: two strobes 4 cycles apart -> overrun=1; the second dac update equals the first; the following sample is still correct.
